// File: rtl/axis_pattern_monitor.sv
// rtl/axis_pattern_monitor.sv - passive AXIS tap that matches packets against masked multi-beat patterns
// Sticky/pulse hit flags plus saturating per-pattern, packet and long-packet counters.
module axis_pattern_monitor #(
  parameter int DATA_WIDTH   = 512,
  parameter int NUM_PATTERNS = 4,
  parameter int MAX_BEATS    = 4,
  parameter int CNT_WIDTH    = 32,
  localparam int PIDX_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
  localparam int BIDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1,
  localparam int LEN_W  = $clog2(MAX_BEATS + 1)
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic [DATA_WIDTH-1:0]           mon_tdata,
  input  logic [DATA_WIDTH/8-1:0]         mon_tkeep,
  input  logic                            mon_tvalid,
  input  logic                            mon_tready,
  input  logic                            mon_tlast,
  input  logic                            arm,
  input  logic                            clear,
  input  logic                            cfg_wr_en,
  input  logic                            cfg_len_wr,
  input  logic [PIDX_W-1:0]               cfg_pat_idx,
  input  logic [BIDX_W-1:0]               cfg_beat_idx,
  input  logic [DATA_WIDTH-1:0]           cfg_data,
  input  logic [DATA_WIDTH-1:0]           cfg_mask,
  input  logic [LEN_W-1:0]                cfg_len,
  output logic [NUM_PATTERNS-1:0]         hit_sticky,
  output logic [NUM_PATTERNS-1:0]         hit_pulse,
  output logic [NUM_PATTERNS*CNT_WIDTH-1:0] match_cnt,
  output logic [CNT_WIDTH-1:0]            pkt_cnt,
  output logic [CNT_WIDTH-1:0]            long_pkt_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IN_PKT,
    ST_OVERFLOW
  } state_e;

  logic [DATA_WIDTH-1:0] pat_data_q [NUM_PATTERNS][MAX_BEATS];
  logic [DATA_WIDTH-1:0] pat_mask_q [NUM_PATTERNS][MAX_BEATS];
  logic [LEN_W-1:0]      pat_len_q  [NUM_PATTERNS];

  state_e                state_q, state_d;
  logic [BIDX_W-1:0]     beat_idx_q, beat_idx_d;
  logic [NUM_PATTERNS-1:0] live_q, live_d;
  logic                  armed_q, armed_d;

  logic [NUM_PATTERNS-1:0] hit_sticky_q, hit_sticky_d;
  logic [NUM_PATTERNS-1:0] hit_pulse_q, hit_pulse_d;
  logic [CNT_WIDTH-1:0]  match_cnt_q [NUM_PATTERNS];
  logic [CNT_WIDTH-1:0]  match_cnt_d [NUM_PATTERNS];
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0]  long_cnt_q, long_cnt_d;

  logic                  beat_acc;
  logic [BIDX_W-1:0]     cur_idx;
  logic                  armed_now;
  logic [NUM_PATTERNS-1:0] live_now;
  logic [NUM_PATTERNS-1:0] hit_now;
  logic                  pkt_end;
  logic                  pkt_long;
  logic [NUM_PATTERNS-1:0] pkt_hits;

  // keep is tapped for completeness but plays no part in matching
  logic unused_keep;
  assign unused_keep = ^mon_tkeep;

  assign beat_acc = mon_tvalid & mon_tready;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int p = 0; p < NUM_PATTERNS; p++) begin
        pat_len_q[p] <= '0;
        for (int b = 0; b < MAX_BEATS; b++) begin
          pat_data_q[p][b] <= '0;
          pat_mask_q[p][b] <= '0;
        end
      end
    end else begin
      if (cfg_wr_en && (int'(cfg_pat_idx) < NUM_PATTERNS) && (int'(cfg_beat_idx) < MAX_BEATS)) begin
        pat_data_q[cfg_pat_idx][cfg_beat_idx] <= cfg_data;
        pat_mask_q[cfg_pat_idx][cfg_beat_idx] <= cfg_mask;
      end
      if (cfg_len_wr && (int'(cfg_pat_idx) < NUM_PATTERNS)) begin
        pat_len_q[cfg_pat_idx] <= cfg_len;
      end
    end
  end

  // The first beat of a packet is evaluated against a fresh all-ones live vector.
  always_comb begin
    cur_idx   = (state_q == ST_IDLE) ? '0 : beat_idx_q;
    armed_now = (state_q == ST_IDLE) ? arm : armed_q;
    for (int p = 0; p < NUM_PATTERNS; p++) begin
      live_now[p] = ((state_q == ST_IDLE) | live_q[p]) &
                    ~|((mon_tdata ^ pat_data_q[p][cur_idx]) & pat_mask_q[p][cur_idx]);
      hit_now[p]  = armed_now & live_now[p] & (pat_len_q[p] != '0) &
                    (pat_len_q[p] == LEN_W'(cur_idx) + LEN_W'(1));
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_idx_d   = beat_idx_q;
    live_d       = live_q;
    armed_d      = armed_q;
    pkt_end      = 1'b0;
    pkt_long     = 1'b0;
    pkt_hits     = '0;
    hit_pulse_d  = '0;
    hit_sticky_d = hit_sticky_q;
    pkt_cnt_d    = pkt_cnt_q;
    long_cnt_d   = long_cnt_q;
    for (int p = 0; p < NUM_PATTERNS; p++) begin
      match_cnt_d[p] = match_cnt_q[p];
    end

    if (beat_acc) begin
      case (state_q)
        ST_IDLE, ST_IN_PKT: begin
          armed_d = armed_now;
          live_d  = live_now;
          if (mon_tlast) begin
            state_d  = ST_IDLE;
            pkt_end  = 1'b1;
            pkt_hits = hit_now;
          end else if (cur_idx == BIDX_W'(MAX_BEATS - 1)) begin
            state_d = ST_OVERFLOW;
          end else begin
            state_d    = ST_IN_PKT;
            beat_idx_d = cur_idx + BIDX_W'(1);
          end
        end
        ST_OVERFLOW: begin
          if (mon_tlast) begin
            state_d  = ST_IDLE;
            pkt_end  = 1'b1;
            pkt_long = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (pkt_end && armed_now) begin
      pkt_cnt_d = sat_inc(pkt_cnt_q);
      if (pkt_long) begin
        long_cnt_d = sat_inc(long_cnt_q);
      end
      for (int p = 0; p < NUM_PATTERNS; p++) begin
        if (pkt_hits[p]) begin
          hit_pulse_d[p]  = 1'b1;
          hit_sticky_d[p] = 1'b1;
          match_cnt_d[p]  = sat_inc(match_cnt_q[p]);
        end
      end
    end

    // clear overrides any update from a coincident tlast beat
    if (clear) begin
      hit_pulse_d  = '0;
      hit_sticky_d = '0;
      pkt_cnt_d    = '0;
      long_cnt_d   = '0;
      for (int p = 0; p < NUM_PATTERNS; p++) begin
        match_cnt_d[p] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      beat_idx_q   <= '0;
      live_q       <= '0;
      armed_q      <= 1'b0;
      hit_sticky_q <= '0;
      hit_pulse_q  <= '0;
      pkt_cnt_q    <= '0;
      long_cnt_q   <= '0;
      for (int p = 0; p < NUM_PATTERNS; p++) begin
        match_cnt_q[p] <= '0;
      end
    end else begin
      state_q      <= state_d;
      beat_idx_q   <= beat_idx_d;
      live_q       <= live_d;
      armed_q      <= armed_d;
      hit_sticky_q <= hit_sticky_d;
      hit_pulse_q  <= hit_pulse_d;
      pkt_cnt_q    <= pkt_cnt_d;
      long_cnt_q   <= long_cnt_d;
      for (int p = 0; p < NUM_PATTERNS; p++) begin
        match_cnt_q[p] <= match_cnt_d[p];
      end
    end
  end

  assign hit_sticky   = hit_sticky_q;
  assign hit_pulse    = hit_pulse_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign long_pkt_cnt = long_cnt_q;

  for (genvar g = 0; g < NUM_PATTERNS; g++) begin : g_cnt_out
    assign match_cnt[g*CNT_WIDTH +: CNT_WIDTH] = match_cnt_q[g];
  end

endmodule

// File: doc/axis_pattern_monitor.md
# axis_pattern_monitor

Passive, parametrised AXI-Stream output monitor for the RMT pipeline. It taps a master AXIS interface without driving it, compares every packet against up to NUM_PATTERNS programmable multi-beat masked patterns, and exposes sticky hit flags, one-cycle hit pulses and saturating per-pattern match counters. It generalises single-value, single-beat output detection into a reusable block. The block is used in simulation benches and in on-board debug taps behind rmt_wrapper.

## Interface
- DATA_WIDTH, 512: AXIS tdata width (bits); tkeep is DATA_WIDTH/8.
- NUM_PATTERNS, 4: number of independent patterns (≥1).
- MAX_BEATS, 4: maximum pattern length in beats (≥1).
- CNT_WIDTH, 32: width of each counter.

- clk  in  1  single clock domain.
- aresetn  in  1  reset, asynchronous, active-low.
- mon_tdata  in  DATA_WIDTH  tapped data.
- mon_tkeep  in  DATA_WIDTH/8  tapped keep; not compared.
- mon_tvalid  in  1  tapped valid.
- mon_tready  in  1  tapped ready.
- mon_tlast  in  1  tapped last.
- arm  in  1  counting enable, sampled on the first beat of each packet.
- clear  in  1  one-cycle pulse; zeroes all flags and counters.
- cfg_wr_en  in  1  writes cfg_data/cfg_mask into (cfg_pat_idx, cfg_beat_idx).
- cfg_len_wr  in  1  writes cfg_len into pattern cfg_pat_idx.
- cfg_pat_idx  in  $clog2(NUM_PATTERNS) (min 1)  pattern select.
- cfg_beat_idx  in  $clog2(MAX_BEATS) (min 1)  beat select.
- cfg_data  in  DATA_WIDTH  expected beat value.
- cfg_mask  in  DATA_WIDTH  1 = bit compared.
- cfg_len  in  $clog2(MAX_BEATS+1)  pattern length in beats; 0 disables the pattern.
- hit_sticky  out  NUM_PATTERNS  set on match, held until clear/reset.
- hit_pulse  out  NUM_PATTERNS  one-cycle match strobe.
- match_cnt  out  NUM_PATTERNS*CNT_WIDTH  per-pattern matches; pattern i is at bits [i*CNT_WIDTH +: CNT_WIDTH].
- pkt_cnt  out  CNT_WIDTH  armed packets completed.
- long_pkt_cnt  out  CNT_WIDTH  armed packets longer than MAX_BEATS.

## Operation
- Beat accepted ⇔ mon_tvalid & mon_tready. Cycles with no accepted beat are ignored.
- FSM states:
  - IDLE: on an accepted beat, latch pkt_armed = arm; beat_idx = 0; set all match_live = 1. Go to IN_PKT, or stay in IDLE if tlast is also set (single-beat packet).
  - IN_PKT: evaluate every accepted beat. After beat MAX_BEATS−1 without tlast, go to OVERFLOW. Return to IDLE on tlast.
  - OVERFLOW: ignore data; return to IDLE on tlast.
- Per beat, for each pattern p: match_live[p] &= ((mon_tdata ^ data[p][beat_idx]) & mask[p][beat_idx]) == 0.
- At the tlast beat (packet length L beats), pattern p hits if all of the following hold:
  - pkt_armed;
  - len[p] != 0;
  - len[p] == L;
  - match_live[p] is still set, including the current beat's comparison.
- On a hit: hit_pulse[p] = 1 for one cycle, hit_sticky[p] = 1, match_cnt[p]++.
- At tlast with pkt_armed set: pkt_cnt++. Also long_pkt_cnt++ if the FSM is in OVERFLOW or the tlast beat index is ≥ MAX_BEATS. Packets that end in OVERFLOW never hit.
- Counters saturate at all-ones and do not wrap.
- Unarmed packets are tracked through the FSM but update nothing.
- Configuration:
  - Writes land at the clock edge. A comparison in the same cycle uses the old contents.
  - Writes mid-packet are legal; the result for that packet is then undefined.
  - Out-of-range indices are ignored.
  - Reset value of all pattern storage is 0, with len = 0 (all patterns disabled).
- clear:
  - Zeroes hit_sticky, match_cnt, pkt_cnt and long_pkt_cnt, and forces hit_pulse to 0 next cycle.
  - If clear coincides with a tlast beat, clear wins: that packet's hits and counts are discarded.
  - clear does not touch the FSM or the configuration.

## Timing
- All outputs are registered.
- hit_pulse, hit_sticky and the counters update on the edge that accepts the tlast beat, so they are visible the following cycle. Latency is 1 cycle from tlast acceptance.
- Back-to-back packets with zero idle cycles are supported: the beat after tlast is the first beat of the next packet.
- Reset (asynchronous, any time, including mid-packet):
  - FSM goes to IDLE; all outputs become 0; configuration is cleared.
  - The first beat accepted after deassertion is treated as the start of a packet.

## Test plan
- Single-beat exact match:
  - Setup: pattern 0, len 1, mask all-ones, data 512'h…0100000002000000030000001a004c4d…; arm = 1.
  - Stimulus: send that beat with tlast.
  - Response: hit_pulse[0] high for exactly 1 cycle; hit_sticky = 4'b0001; match_cnt[0] = 1; pkt_cnt = 1.
- Masked 2-beat match:
  - Setup: pattern 1, len 2; beat-1 mask covers only the low 160 bits.
  - Stimulus: send a packet whose upper beat-1 bits differ from the pattern.
  - Response: pattern 1 hits.
  - Follow-up: flip bit 0 of beat 0 and resend. Response: no hit; match_cnt[1] stays 1.
- Length mismatch and overflow:
  - Case 1: send a 3-beat packet whose first 2 beats equal a len-2 pattern. Response: no hit.
  - Case 2 (MAX_BEATS = 4): send a 6-beat packet. Response: long_pkt_cnt = 1; no hits; FSM returns to IDLE after tlast.
- Arm gating and back-to-back:
  - Stimulus: a matching packet with arm = 0, then immediately (zero gap) the same packet with arm = 1.
  - Response: exactly 1 hit; pkt_cnt = 1.
- tready stalls:
  - Stimulus: a matching 3-beat packet with mon_tready low for 2 cycles between beats while tvalid stays high.
  - Response: hit is counted exactly once.
- Clear/reset corners:
  - clear in the same cycle as a matching tlast: all counters 0 and no pulse.
  - aresetn asserted mid-packet, then a fresh matching packet after reprogramming: exactly 1 hit.
  - Counter preloaded near saturation (CNT_WIDTH = 4, 16 hits): match_cnt holds at 4'hF.
